// File: rtl/ps2_scan_sequencer.sv
// Purpose: turn PS/2 Set-2 scan bytes (E0/F0/E1 prefixes) into single key events, buffered in a FIFO.
// Latency: the byte completing an event is written at edge N; head visible after N when FIFO was empty.
// Backpressure: valid/ready pop; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
// Optional macro PS2_SEQ_TIMEOUT_EN: enables the stalled-prefix abort counter (timeout tied low otherwise).
`timescale 1ns/1ps

module ps2_scan_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clock_fpga,
  input  logic                          reset,
  input  logic [7:0]                    code_in,
  input  logic                          code_valid,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          ev_pause,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       pause;
  } ev_t;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t         state;
  logic [2:0]     pause_cnt;
  logic           push;
  ev_t            push_ev;
  logic           pop;
  logic           full;
  logic           push_ok;
  logic           ovf_set;
  logic           to_fire;

  ev_t            mem [FIFO_DEPTH];
  ev_t            head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  // Decide whether the incoming byte completes an event, and what that event is
  always_comb begin
    push    = 1'b0;
    push_ev = '0;
    if (code_valid) begin
      case (state)
        IDLE: begin
          case (code_in)
            8'hE0, 8'hF0, 8'hE1,
            8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE: push = 1'b0;
            default: begin
              push    = 1'b1;
              push_ev = '{code: code_in, ext: 1'b0, brk: 1'b0, pause: 1'b0};
            end
          endcase
        end
        EXT: begin
          // F0 and a repeated E0 keep the sequence open; 12 is the fake shift
          if (code_in != 8'hF0 && code_in != 8'hE0 && code_in != 8'h12) begin
            push    = 1'b1;
            push_ev = '{code: code_in, ext: 1'b1, brk: 1'b0, pause: 1'b0};
          end
        end
        BRK: begin
          push    = 1'b1;
          push_ev = '{code: code_in, ext: 1'b0, brk: 1'b1, pause: 1'b0};
        end
        EXT_BRK: begin
          if (code_in != 8'h12) begin
            push    = 1'b1;
            push_ev = '{code: code_in, ext: 1'b1, brk: 1'b1, pause: 1'b0};
          end
        end
        PAUSE: begin
          // The last of the seven trailing bytes yields the single Pause event
          if (pause_cnt <= 3'd1) begin
            push    = 1'b1;
            push_ev = '{code: 8'h77, ext: 1'b0, brk: 1'b0, pause: 1'b1};
          end
        end
        default: push = 1'b0;
      endcase
    end
  end

  // Prefix sequencer; a timeout abort takes priority only when no byte arrives that cycle
  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pause_cnt <= 3'd0;
    end else if (to_fire) begin
      state     <= IDLE;
      pause_cnt <= 3'd0;
    end else if (code_valid) begin
      case (state)
        IDLE: begin
          if (code_in == 8'hE0) begin
            state <= EXT;
          end else if (code_in == 8'hF0) begin
            state <= BRK;
          end else if (code_in == 8'hE1) begin
            state     <= PAUSE;
            pause_cnt <= 3'd7;
          end
        end
        EXT: begin
          if (code_in == 8'hF0) begin
            state <= EXT_BRK;
          end else if (code_in != 8'hE0) begin
            state <= IDLE;
          end
        end
        BRK:     state <= IDLE;
        EXT_BRK: state <= IDLE;
        PAUSE: begin
          if (pause_cnt <= 3'd1) begin
            state     <= IDLE;
            pause_cnt <= 3'd0;
          end else begin
            pause_cnt <= pause_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PS2_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] to_cnt;

  assign to_fire = (state != IDLE) && !code_valid && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter inside a partial sequence, plus the one-cycle abort pulse
  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= to_fire;
      if (code_valid || state == IDLE || to_fire) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign to_fire            = 1'b0;
  assign timeout            = 1'b0;
`endif

  assign full     = (count == CW'(FIFO_DEPTH));
  assign ev_valid = (count != '0);
  assign pop      = ev_valid & ev_ready;
  assign push_ok  = push & (~full | pop);
  assign ovf_set  = push & full & ~pop;

  // Event storage; contents need no reset because count gates every read
  always_ff @(posedge clock_fpga) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_ev;
    end
  end

  // Pointers, occupancy and the registered show-ahead head
  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Head moves on pop, or loads directly when an empty FIFO receives a push
      if (pop) begin
        if (count > CW'(1)) begin
          head <= mem[rd_ptr + AW'(1)];
        end else if (push_ok) begin
          head <= push_ev;
        end
      end else if (count == '0 && push_ok) begin
        head <= push_ev;
      end
    end
  end

  // Sticky overflow; a same-cycle drop beats the clear
  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  assign ev_code    = head.code;
  assign ev_ext     = head.ext;
  assign ev_break   = head.brk;
  assign ev_pause   = head.pause;
  assign fifo_count = count;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer (FIFO_DEPTH=4, TIMEOUT_CYCLES=50).
// Inputs change on the falling edge; outputs are checked on the following falling edge.
// Timeout expectations follow PS2_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps

module tb_ps2_scan_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] code_in;
  logic       code_valid;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_pause;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clr_overflow;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  ps2_scan_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(50)) dut (
    .clock_fpga   (clk),
    .reset        (reset),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_break     (ev_break),
    .ev_pause     (ev_pause),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One code_valid pulse; returns on the falling edge after the byte was taken
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_in    = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  // Check the head event, then pop it with a one-cycle ready
  task automatic pop_check(input string tag, input logic [7:0] c, input logic e,
                           input logic b, input logic p);
    chk({tag, " valid"}, ev_valid, 1);
    chk({tag, " head"}, {ev_code, ev_ext, ev_break, ev_pause}, {c, e, b, p});
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    code_in      = 8'h00;
    code_valid   = 1'b0;
    ev_ready     = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst ev_valid", ev_valid, 0);
    chk("rst head", {ev_code, ev_ext, ev_break, ev_pause}, 0);
    chk("rst count", fifo_count, 0);
    chk("rst overflow", overflow, 0);
    chk("rst timeout", timeout, 0);
    reset = 1'b1;
    @(negedge clk);

    // Plain make code with ready held high: valid for exactly one cycle
    ev_ready = 1'b1;
    send(8'h1C);
    chk("make valid", ev_valid, 1);
    chk("make head", {ev_code, ev_ext, ev_break, ev_pause}, {8'h1C, 3'b000});
    @(negedge clk);
    chk("make valid drop", ev_valid, 0);
    chk("make count", fifo_count, 0);
    ev_ready = 1'b0;

    // Extended break
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("extbrk count", fifo_count, 1);
    pop_check("extbrk", 8'h75, 1'b1, 1'b1, 1'b0);

    // Fake shift is dropped, the real extended key follows
    send(8'hE0); send(8'h12);
    chk("fakeshift count", fifo_count, 0);
    send(8'hE0); send(8'h7C);
    chk("ext count", fifo_count, 1);
    pop_check("ext", 8'h7C, 1'b1, 1'b0, 1'b0);

    // Pause: eight bytes, one event
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause partial count", fifo_count, 0);
    send(8'h77);
    chk("pause count", fifo_count, 1);
    pop_check("pause", 8'h77, 1'b0, 1'b0, 1'b1);

    // Status bytes are filtered
    send(8'hAA); send(8'hFA);
    chk("status count", fifo_count, 0);
    chk("status valid", ev_valid, 0);

    // Overflow with ready low
    send(8'h15); send(8'h16); send(8'h1E); send(8'h26);
    chk("fill no overflow", overflow, 0);
    send(8'h25); send(8'h2E);
    chk("full count", fifo_count, 4);
    chk("overflow set", overflow, 1);
    pop_check("drain0", 8'h15, 1'b0, 1'b0, 1'b0);
    pop_check("drain1", 8'h16, 1'b0, 1'b0, 1'b0);
    pop_check("drain2", 8'h1E, 1'b0, 1'b0, 1'b0);
    pop_check("drain3", 8'h26, 1'b0, 1'b0, 1'b0);
    chk("drained count", fifo_count, 0);
    chk("overflow sticky", overflow, 1);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("overflow clear", overflow, 0);

    // Full FIFO with push and pop in the same cycle: nothing lost
    send(8'h15); send(8'h16); send(8'h1E); send(8'h26);
    code_in    = 8'h25;
    code_valid = 1'b1;
    ev_ready   = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    ev_ready   = 1'b0;
    chk("pushpop count", fifo_count, 4);
    chk("pushpop overflow", overflow, 0);
    pop_check("pp0", 8'h16, 1'b0, 1'b0, 1'b0);
    pop_check("pp1", 8'h1E, 1'b0, 1'b0, 1'b0);
    pop_check("pp2", 8'h26, 1'b0, 1'b0, 1'b0);
    pop_check("pp3", 8'h25, 1'b0, 1'b0, 1'b0);
    chk("pp empty", ev_valid, 0);

`ifdef PS2_SEQ_TIMEOUT_EN
    // Stalled E0 is aborted on the 50th idle edge
    send(8'hE0);
    repeat (49) @(negedge clk);
    chk("timeout early", timeout, 0);
    @(negedge clk);
    chk("timeout pulse", timeout, 1);
    @(negedge clk);
    chk("timeout one cycle", timeout, 0);
    chk("timeout no event", fifo_count, 0);
    send(8'h1C);
    pop_check("after timeout", 8'h1C, 1'b0, 1'b0, 1'b0);
`else
    // Without the abort logic the E0 prefix survives the idle period
    send(8'hE0);
    repeat (60) @(negedge clk);
    chk("timeout tied", timeout, 0);
    chk("no abort event", fifo_count, 0);
    send(8'h1C);
    pop_check("no timeout", 8'h1C, 1'b1, 1'b0, 1'b0);
`endif

    // Reset mid-sequence discards the partial break and stored events
    send(8'h1C);
    send(8'hF0);
    chk("pre-reset count", fifo_count, 1);
    reset = 1'b0;
    #1;
    chk("mid rst count", fifo_count, 0);
    chk("mid rst valid", ev_valid, 0);
    chk("mid rst head", {ev_code, ev_ext, ev_break, ev_pause}, 0);
    chk("mid rst timeout", timeout, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(8'h2B);
    pop_check("post reset", 8'h2B, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_sequencer.md
# ps2_scan_sequencer

Consumes the byte stream from the PS/2 receiver (8-bit code plus one-cycle new-code pulse) and sequences multi-byte Set-2 scan codes into single key events. Handles the E0 (extended), F0 (break) and E1 (Pause) prefixes. Filters keyboard status bytes and aborts stalled prefix sequences with a timeout. Decoded events are buffered in a small FIFO with a valid/ready handshake toward the application logic (OSD/camera control).

## Interface
Parameters:
- FIFO_DEPTH, 4 — event FIFO depth; power of two, ≥ 2.
- TIMEOUT_CYCLES, 100000 — idle clocks inside a partial sequence before abort (2 ms at 50 MHz); ≥ 2.

Ports:
- clock_fpga  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- code_in  in  8  scan byte from receiver; sampled only when code_valid = 1.
- code_valid  in  1  one-cycle pulse per received byte.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts head.
- ev_code  out  8  key code of head event.
- ev_ext  out  1  head event had E0 prefix.
- ev_break  out  1  head event is a release (F0 seen).
- ev_pause  out  1  head event is the Pause key.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  events stored.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- clr_overflow  in  1  clears overflow.
- timeout  out  1  one-cycle pulse when a partial sequence is aborted.

## Operation
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions occur only on code_valid, except timeout.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE, with pause_cnt = 7.
  - 00, FF, AA, FA, EE, FE → dropped, stay IDLE.
  - Any other byte → push {code, ext=0, brk=0, pause=0}.
- EXT:
  - F0 → EXT_BRK.
  - E0 → stay EXT.
  - 12 (fake shift) → drop, go IDLE.
  - Other → push {ext=1, brk=0}, go IDLE.
- BRK: any byte → push {brk=1, ext=0}, go IDLE.
- EXT_BRK:
  - 12 → drop, go IDLE.
  - Other → push {ext=1, brk=1}, go IDLE.
- PAUSE:
  - Each byte decrements pause_cnt; byte content is ignored.
  - When pause_cnt reaches 0 on the 7th byte, push {code=77, ext=0, brk=0, pause=1} and go IDLE.
- FIFO:
  - Push is accepted when not full, or when full and a pop occurs in the same cycle (count unchanged).
  - A push rejected when full sets overflow; the FSM still advances normally.
  - Pop occurs on ev_valid & ev_ready. Pop when empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Cleared by clr_overflow.
  - If a set and a clear occur in the same cycle, set wins.
- Timeout (macro-controlled):
  - Counter clears on every code_valid and while in IDLE.
  - Counter increments otherwise.
  - On reaching TIMEOUT_CYCLES−1 the FSM returns to IDLE, pause_cnt clears, no event is pushed, and timeout pulses for one cycle.
  - If code_valid coincides with the terminal count, the byte is processed and the timeout is suppressed.

## Timing
- Reset values: ev_valid=0, ev_code=00, ev_ext=0, ev_break=0, ev_pause=0, fifo_count=0, overflow=0, timeout=0. FSM=IDLE, pointers=0, timeout counter=0.
- Reset mid-sequence discards any partial sequence and all FIFO contents immediately (asynchronous).
- Latency: code_valid completing an event at edge N → FIFO written at edge N → ev_valid=1 and head fields valid after edge N (visible cycle N+1) if the FIFO was empty.
- Head fields are registered (show-ahead) and stable while ev_valid=1 and ev_ready=0.
- fifo_count updates on the same edge as push/pop.
- Back-to-back code_valid pulses on consecutive cycles are fully supported; one byte is processed per cycle.

## Configuration
- PS2_SEQ_TIMEOUT_EN defined: timeout counter and abort logic are present as described.
- Not defined: no counter is instantiated, a partial sequence waits indefinitely, and timeout is tied to 0. All other behaviour is identical.

## Test plan
- Bytes 1C with ev_ready=1 → one event {ev_code=1C, ext=0, break=0, pause=0}; ev_valid high exactly 1 cycle.
- Bytes E0 F0 75 → one event {75, ext=1, break=1}. Bytes E0 12 E0 7C → one event {7C, ext=1, break=0}; no event for the 12.
- Bytes E1 14 77 E1 F0 14 F0 77 → exactly one event {77, pause=1}, fifo_count=1. Bytes AA and FA alone → no events.
- FIFO_DEPTH=4, ev_ready=0, six make codes 15 16 1E 26 25 2E → fifo_count=4, overflow=1. Then pop all with ev_ready=1 → heads 15,16,1E,26. clr_overflow → overflow=0.
- With the macro defined, TIMEOUT_CYCLES=50: E0, then 50 idle cycles → timeout pulse, FSM=IDLE. Next byte 1C → event {1C, ext=0}. Without the macro, the same stimulus → event {1C, ext=1}.
- Assert reset low between F0 and 2B, release, send 2B → event {2B, break=0}. All outputs at reset values during reset.
